// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader, the memory it feeds and its bench.
// Covers memory geometry, the byte-stream format and the loader state encoding.
package imem_loader_pkg;

  localparam int IMEM_DEPTH     = 64;
  localparam int IMEM_ADDR_W    = 6;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int LEN_MIN        = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // A length byte is usable only if it names 1..depth words.
  function automatic logic len_is_legal(input logic [BYTE_W-1:0] len, input int depth);
    return (int'(len) >= LEN_MIN) && (int'(len) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Assembles four consecutive stream bytes into one little-endian 32-bit word.
// The word output already includes the byte being accepted, so it is complete when word_full is high.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_full,
  output logic [WORD_W-1:0] word
);

  logic [BYTE_IDX_W-1:0] idx_reg;
  logic [WORD_W-1:0]     word_reg;
  logic [WORD_W-1:0]     word_next;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign word_next[gi*BYTE_W +: BYTE_W] =
        (byte_valid && (idx_reg == BYTE_IDX_W'(gi))) ? byte_data : word_reg[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  assign word_full = byte_valid && (idx_reg == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign word      = word_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg  <= '0;
      word_reg <= '0;
    end else if (clear) begin
      idx_reg  <= '0;
    end else if (byte_valid) begin
      idx_reg  <= idx_reg + 1'b1;
      word_reg <= word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into the instruction memory write port,
// holding the CPU until a load completes successfully.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH          = IMEM_DEPTH,
  parameter int ADDR_W         = IMEM_ADDR_W,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    len_reg;
  logic [CNT_W-1:0]    words_reg;
  logic [TO_W-1:0]     idle_cnt_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [WORD_W-1:0]   mem_wdata_reg;
  logic                cpu_hold_reg;
  logic                error_reg;
  logic                xfer;
  logic                len_bad;
  logic                timeout_hit;
  logic                word_full;
  logic [WORD_W-1:0]   packed_word;

  assign xfer        = in_valid && in_ready;
  assign len_bad     = !len_is_legal(in_data, DEPTH);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !xfer && (idle_cnt_reg == TO_LAST);

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state_reg == ST_IDLE),
    .byte_valid (state_reg == ST_DATA && in_valid),
    .byte_data  (in_data),
    .word_full  (word_full),
    .word       (packed_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_LEN;
      ST_LEN: begin
        if (xfer)             state_next = len_bad ? ST_ERR : ST_DATA;
        else if (timeout_hit) state_next = ST_ERR;
      end
      ST_DATA: begin
        if (word_full)        state_next = ST_WRITE;
        else if (timeout_hit) state_next = ST_ERR;
      end
      ST_WRITE: state_next = ((words_reg + 1'b1) == len_reg) ? ST_DONE : ST_DATA;
      ST_DONE:  state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == ST_LEN) || (state_reg == ST_DATA);
    mem_we   = (state_reg == ST_WRITE);
    busy     = (state_reg != ST_IDLE);
    done     = (state_reg == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg       <= '0;
      words_reg     <= '0;
      idle_cnt_reg  <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cpu_hold_reg  <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && start) begin
        cpu_hold_reg <= 1'b1;
        error_reg    <= 1'b0;
        words_reg    <= '0;
      end
      if (state_reg == ST_LEN && xfer && !len_bad) len_reg <= CNT_W'(in_data);
      // Address and data are captured with the 4th byte and then held until the next word.
      if (state_reg == ST_DATA && word_full) begin
        mem_addr_reg  <= words_reg[ADDR_W-1:0];
        mem_wdata_reg <= packed_word;
      end
      if (state_reg == ST_WRITE) words_reg <= words_reg + 1'b1;
      if (state_next == ST_DONE) cpu_hold_reg <= 1'b0;
      if (state_next == ST_ERR)  error_reg    <= 1'b1;
      // Idle counter only advances while waiting for a byte; any transfer or other state clears it.
      if ((state_reg == ST_LEN || state_reg == ST_DATA) && !xfer && (TIMEOUT_CYCLES != 0))
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      else
        idle_cnt_reg <= '0;
    end
  end

  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign cpu_hold     = cpu_hold_reg;
  assign error        = error_reg;
  assign words_loaded = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a stream-level reference model predicts every output each cycle,
// and literal expectations pin the directed loads.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int T = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, mem_we, cpu_hold, busy, done, error;
  logic [5:0]        mem_addr;
  logic [31:0]       mem_wdata;
  logic [6:0]        words_loaded;

  imem_loader #(.DEPTH(IMEM_DEPTH), .ADDR_W(IMEM_ADDR_W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the stream position and the expected output of the current cycle.
  bit          m_rx, m_have_len, m_hold, m_err, m_pw, m_pd, m_pe;
  int          m_n, m_count, m_idle;
  logic [7:0]  m_bytes[$];
  logic [5:0]  m_addr;
  logic [31:0] m_data;

  logic [31:0] obs_mem[64];
  int          obs_cnt[64];
  int          obs_writes;

  task automatic model_reset();
    m_rx = 0; m_have_len = 0; m_hold = 0; m_err = 0; m_pw = 0; m_pd = 0; m_pe = 0;
    m_n = 0; m_count = 0; m_idle = 0; m_bytes.delete(); m_addr = '0; m_data = '0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      chk("mem_we",       32'(mem_we),       32'(m_pw));
      chk("mem_addr",     32'(mem_addr),     32'(m_addr));
      chk("mem_wdata",    mem_wdata,         m_data);
      chk("in_ready",     32'(in_ready),     32'(m_rx));
      chk("busy",         32'(busy),         32'(m_rx | m_pw | m_pd | m_pe));
      chk("done",         32'(done),         32'(m_pd));
      chk("error",        32'(error),        32'(m_err));
      chk("cpu_hold",     32'(cpu_hold),     32'(m_hold));
      chk("words_loaded", 32'(words_loaded), 32'(m_count));
      if (mem_we) begin
        obs_mem[mem_addr] = mem_wdata;
        obs_cnt[mem_addr]++;
        obs_writes++;
      end
      if (m_pw) begin
        m_pw = 0; m_idle = 0; m_count++;
        if (m_count == m_n) begin m_pd = 1; m_hold = 0; end
        else m_rx = 1;
      end else if (m_pd) begin
        m_pd = 0;
      end else if (m_pe) begin
        m_pe = 0;
      end else if (m_rx) begin
        if (in_valid) begin
          m_idle = 0;
          if (!m_have_len) begin
            if (int'(in_data) == 0 || int'(in_data) > IMEM_DEPTH) begin
              m_err = 1; m_pe = 1; m_rx = 0;
            end else begin
              m_n = int'(in_data); m_have_len = 1;
            end
          end else begin
            m_bytes.push_back(in_data);
            if (m_bytes.size() == 4) begin
              m_data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
              m_addr = m_count[5:0];
              m_pw = 1; m_rx = 0;
              m_bytes.delete();
            end
          end
        end else begin
          m_idle++;
          if (m_idle == T) begin m_err = 1; m_pe = 1; m_rx = 0; end
        end
      end else if (start) begin
        m_rx = 1; m_have_len = 0; m_hold = 1; m_err = 0; m_count = 0; m_idle = 0;
        m_bytes.delete();
      end
    end
  end

  logic [31:0] ld_words[64];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 64; i++) begin obs_mem[i] = '0; obs_cnt[i] = 0; end
    obs_writes = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    in_valid = 1'b1; in_data = b;
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (in_ready) break;
      if (k > 100) begin
        chk("accept_wait", 32'(0), 32'(1));
        in_valid = 1'b0;
        tick();
        return;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_words(input int nw, input int nbytes_limit, input int gmin, input int gmax);
    int sent = 0;
    for (int i = 0; i < nw; i++)
      for (int k = 0; k < 4; k++)
        if (sent < nbytes_limit) begin
          send_byte(8'(ld_words[i] >> (8 * k)), int'($urandom_range(gmax, gmin)));
          sent++;
        end
  endtask

  task automatic wait_idle();
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (!busy) break;
      if (k > 1000) begin chk("idle_wait", 32'(busy), 32'(0)); break; end
    end
    tick();
  endtask

  task automatic load(input int n, input int gmin, input int gmax);
    pulse_start();
    send_byte(8'(n), int'($urandom_range(gmax, gmin)));
    send_words(n, 4 * n, gmin, gmax);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_obs();
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_cpu_hold", 32'(cpu_hold), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_words", 32'(words_loaded), 32'(0));
    rst_n = 1'b1;
    tick();

    // Three-word program sent back to back, then with 10-cycle gaps.
    for (int pass = 0; pass < 2; pass++) begin
      clear_obs();
      ld_words[0] = 32'h0000_2083; ld_words[1] = 32'h0040_2103; ld_words[2] = 32'h0080_2183;
      load(3, pass * 10, pass * 10);
      chk("t1_word0", obs_mem[0], 32'h0000_2083);
      chk("t1_word1", obs_mem[1], 32'h0040_2103);
      chk("t1_word2", obs_mem[2], 32'h0080_2183);
      chk("t1_writes", 32'(obs_writes), 32'(3));
      chk("t1_words_loaded", 32'(words_loaded), 32'(3));
      chk("t1_cpu_hold", 32'(cpu_hold), 32'(0));
      chk("t1_error", 32'(error), 32'(0));
    end

    // Illegal lengths, then a good single-word load.
    clear_obs();
    pulse_start(); send_byte(8'd0, 0); wait_idle();
    chk("t3_len0_error", 32'(error), 32'(1));
    chk("t3_len0_hold", 32'(cpu_hold), 32'(1));
    pulse_start(); send_byte(8'd65, 2); wait_idle();
    chk("t3_len65_error", 32'(error), 32'(1));
    chk("t3_len65_hold", 32'(cpu_hold), 32'(1));
    chk("t3_no_writes", 32'(obs_writes), 32'(0));
    ld_words[0] = $urandom;
    load(1, 0, 2);
    chk("t3_recover_error", 32'(error), 32'(0));
    chk("t3_recover_hold", 32'(cpu_hold), 32'(0));
    chk("t3_recover_word", obs_mem[0], ld_words[0]);

    // Stream stalls after 5 of 8 data bytes.
    clear_obs();
    ld_words[0] = $urandom; ld_words[1] = $urandom;
    pulse_start(); send_byte(8'd2, 0); send_words(2, 5, 0, 1);
    repeat (T + 8) tick();
    chk("t4_writes", 32'(obs_writes), 32'(1));
    chk("t4_addr1_untouched", 32'(obs_cnt[1]), 32'(0));
    chk("t4_error", 32'(error), 32'(1));
    chk("t4_busy", 32'(busy), 32'(0));

    // Full-depth load with word i = i.
    clear_obs();
    for (int i = 0; i < 64; i++) ld_words[i] = 32'(i);
    load(64, 0, 0);
    chk("t5_last_word", obs_mem[63], 32'd63);
    chk("t5_writes", 32'(obs_writes), 32'(64));
    chk("t5_addr0_once", 32'(obs_cnt[0]), 32'(1));
    chk("t5_words_loaded", 32'(words_loaded), 32'(64));

    // Random loads with random gaps.
    for (int r = 0; r < 6; r++) begin
      int n;
      clear_obs();
      n = int'($urandom_range(8, 1));
      for (int i = 0; i < n; i++) ld_words[i] = $urandom;
      load(n, 0, 4);
      chk("rnd_last_word", obs_mem[n-1], ld_words[n-1]);
    end

    // Reset mid-load, with a start pulse while busy that must be ignored.
    ld_words[0] = $urandom; ld_words[1] = $urandom;
    pulse_start(); send_byte(8'd3, 0); send_words(2, 6, 0, 0);
    pulse_start();
    chk("t6_busy_before_rst", 32'(busy), 32'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'(0));
    chk("t6_rst_hold", 32'(cpu_hold), 32'(0));
    chk("t6_rst_in_ready", 32'(in_ready), 32'(0));
    chk("t6_rst_words", 32'(words_loaded), 32'(0));
    chk("t6_rst_addr", 32'(mem_addr), 32'(0));
    chk("t6_rst_wdata", mem_wdata, 32'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    clear_obs();
    ld_words[0] = $urandom;
    load(1, 0, 1);
    chk("t6_reload_addr0", 32'(obs_cnt[0]), 32'(1));
    chk("t6_reload_word", obs_mem[0], ld_words[0]);
    chk("t6_reload_writes", 32'(obs_writes), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
